// File: rtl/first_vector_vxv_chunk_reader.sv
// Chunk reader for the first-vector VxV storage word.
// A start pulse snapshots the padded vector word. The snapshot is then
// streamed to the compute lanes one no_of_units-wide chunk at a time,
// lowest-indexed element first.
//
// Handshake: chunk_valid/chunk_out/chunk_index/last_chunk are driven from
// registered state only. A chunk transfers on a rising edge where
// chunk_valid && chunk_ready. While valid is high without ready, the chunk
// holds stable. chunk_ready is ignored while chunk_valid is low.
module first_vector_vxv_chunk_reader #(
    parameter int element_width                   = 32,
    parameter int number_of_equations_per_cluster = 9,
    parameter int no_of_units                     = 8,
    parameter int additional                      = no_of_units - (number_of_equations_per_cluster % no_of_units),
    parameter int total                           = number_of_equations_per_cluster + additional,
    parameter int number_of_chunks                = total / no_of_units,
    parameter int index_width                     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [element_width*total-1:0]       memory_output,
    input  logic                                 start,
    output logic [element_width*no_of_units-1:0] chunk_out,
    output logic                                 chunk_valid,
    input  logic                                 chunk_ready,
    output logic [index_width-1:0]               chunk_index,
    output logic                                 last_chunk,
    output logic                                 busy,
    output logic                                 done
);

    localparam int CW = element_width * no_of_units;
    localparam int TW = element_width * total;
    localparam logic [index_width-1:0] LAST_IDX = index_width'(number_of_chunks - 1);
    localparam logic [index_width-1:0] ONE_IDX  = index_width'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          snap_q, snap_d;
    logic [index_width-1:0] idx_q, idx_d;
    logic [TW-1:0]          snap_shifted;
    logic                   transfer;

    assign transfer = (state_q == S_STREAM) && chunk_ready;

    // Next-state logic: snapshot on start, advance on each transfer,
    // single DONE cycle after the final transfer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = memory_output;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (transfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + ONE_IDX;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, snapshot and index registers; reset wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
        end
    end

    // Chunk k sits k chunk-widths below the MSB end of the snapshot, so
    // shifting it up to the top makes the slice a constant part-select.
    always_comb begin
        snap_shifted = snap_q << (idx_q * CW);
        chunk_out    = snap_shifted[TW-1 -: CW];
    end

    assign chunk_valid = (state_q == S_STREAM);
    assign chunk_index = idx_q;
    assign last_chunk  = (state_q == S_STREAM) && (idx_q == LAST_IDX);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_first_vector_vxv_chunk_reader.sv
// Bench for first_vector_vxv_chunk_reader: default 9-element instance and a
// 16-element (exact multiple) instance sharing clock and reset.
module tb_first_vector_vxv_chunk_reader;

  localparam int W = 265;  // {last, index[7:0], chunk[255:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // ---------------- DUT A (defaults: 9 elems, 2 chunks) ----------------
  logic [511:0] mem_a;
  logic         start_a, ready_a;
  logic [255:0] out_a;
  logic         valid_a, last_a, busy_a, done_a;
  logic [7:0]   idx_a;

  first_vector_vxv_chunk_reader u_dut_a (
    .clk(clk), .reset(reset), .memory_output(mem_a), .start(start_a),
    .chunk_out(out_a), .chunk_valid(valid_a), .chunk_ready(ready_a),
    .chunk_index(idx_a), .last_chunk(last_a), .busy(busy_a), .done(done_a)
  );

  // ---------------- DUT B (16 elems, 3 chunks) ----------------
  logic [767:0] mem_b;
  logic         start_b, ready_b;
  logic [255:0] out_b;
  logic         valid_b, last_b, busy_b, done_b;
  logic [7:0]   idx_b;

  first_vector_vxv_chunk_reader #(.number_of_equations_per_cluster(16)) u_dut_b (
    .clk(clk), .reset(reset), .memory_output(mem_b), .start(start_b),
    .chunk_out(out_b), .chunk_valid(valid_b), .chunk_ready(ready_b),
    .chunk_index(idx_b), .last_chunk(last_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- scoreboard queues ----------------
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int           done_cyc_a[$];
  int           done_cyc_b[$];

  // ---------------- reference model ----------------
  function automatic logic [511:0] vec_a(input int base);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[511-32*i -: 32] = 32'(base + i);
    return v;
  endfunction

  function automatic logic [767:0] vec_b(input int base);
    logic [767:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[767-32*i -: 32] = 32'(base + i);
    return v;
  endfunction

  // Chunk k of a vector whose element i is base+i for i < neq, zero beyond.
  function automatic logic [W-1:0] item(input int neq, input int base,
                                        input int k, input int nch);
    logic [255:0] d;
    int e;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      e = k * 8 + j;
      if (e < neq) d[255-32*j -: 32] = 32'(base + e);
    end
    return {(k == nch - 1), 8'(k), d};
  endfunction

  // ---------------- checker helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_a_t(input logic [511:0] v, input int base, input bit push,
                           input int done_off);
    mem_a   = v;
    start_a = 1'b1;
    if (push) begin
      for (int k = 0; k < 2; k++) exp_a.push_back(item(9, base, k, 2));
      done_cyc_a.push_back(cyc + 1 + done_off);
    end
    step();
    start_a = 1'b0;
    chk("a_valid_after_start", 64'(valid_a), 64'd1);
    chk("a_busy_after_start", 64'(busy_a), 64'd1);
  endtask

  task automatic start_b_t(input int base, input int done_off);
    mem_b   = vec_b(base);
    start_b = 1'b1;
    for (int k = 0; k < 3; k++) exp_b.push_back(item(16, base, k, 3));
    done_cyc_b.push_back(cyc + 1 + done_off);
    step();
    start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      step();
      n++;
    end
    chk(name, 64'(busy_a), 64'd0);
  endtask

  task automatic wait_idle_b(input string name);
    int n;
    n = 0;
    while (busy_b && n < 40) begin
      step();
      n++;
    end
    chk(name, 64'(busy_b), 64'd0);
  endtask

  // ---------------- monitors ----------------
  // Compare the presented chunk with the queue head every cycle it is valid
  // (covers hold-stability); pop only when the transfer will occur.
  always @(negedge clk) begin
    logic [W-1:0] got;
    int dc;
    if (!reset) begin
      got = {last_a, idx_a, out_a};
      if (valid_a) begin
        if (exp_a.size() == 0) begin
          if (ready_a) begin
            checks++; fails++;
            $display("FAIL a_chunk_unexpected: got %h expected none", got);
          end
        end else begin
          checks++;
          if (got !== exp_a[0]) begin
            fails++;
            $display("FAIL a_chunk: got %h expected %h", got, exp_a[0]);
          end
          if (ready_a) void'(exp_a.pop_front());
        end
      end
      if (done_a) begin
        checks++;
        if (done_cyc_a.size() == 0) begin
          fails++;
          $display("FAIL a_done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          dc = done_cyc_a.pop_front();
          if (dc != cyc) begin
            fails++;
            $display("FAIL a_done_cycle: got %0d expected %0d", cyc, dc);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] got;
    int dc;
    if (!reset) begin
      got = {last_b, idx_b, out_b};
      if (valid_b) begin
        if (exp_b.size() == 0) begin
          if (ready_b) begin
            checks++; fails++;
            $display("FAIL b_chunk_unexpected: got %h expected none", got);
          end
        end else begin
          checks++;
          if (got !== exp_b[0]) begin
            fails++;
            $display("FAIL b_chunk: got %h expected %h", got, exp_b[0]);
          end
          if (ready_b) void'(exp_b.pop_front());
        end
      end
      if (done_b) begin
        checks++;
        if (done_cyc_b.size() == 0) begin
          fails++;
          $display("FAIL b_done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          dc = done_cyc_b.pop_front();
          if (dc != cyc) begin
            fails++;
            $display("FAIL b_done_cycle: got %0d expected %0d", cyc, dc);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset   = 1'b1;
    start_a = 1'b0; ready_a = 1'b0; mem_a = '0;
    start_b = 1'b0; ready_b = 1'b0; mem_b = '0;
    step();
    step();

    // Reset values
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_last", 64'(last_a), 64'd0);
    chk("rst_index", 64'(idx_a), 64'd0);
    chk("rst_chunk_out", out_a[63:0], 64'd0);

    // Reset has priority over a simultaneous start
    mem_a   = vec_a(1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    reset   = 1'b0;
    chk("rst_prio_busy", 64'(busy_a), 64'd0);
    step();
    chk("rst_prio_valid", 64'(valid_a), 64'd0);

    // Defaults: 1..9 with ready held high, done two edges after start edge
    ready_a = 1'b1;
    start_a_t(vec_a(1), 1, 1'b1, 2);
    wait_idle_a("t1_idle");

    // Back-pressure: ready low for 4 cycles on chunk 0
    ready_a = 1'b0;
    start_a_t(vec_a(101), 101, 1'b1, 6);
    chk("bp_index_hold", 64'(idx_a), 64'd0);
    repeat (4) step();
    chk("bp_index_still_0", 64'(idx_a), 64'd0);
    ready_a = 1'b1;
    wait_idle_a("bp_idle");

    // Snapshot isolation: store rewritten right after the start edge
    ready_a = 1'b0;
    start_a_t(vec_a(1), 1, 1'b1, 3);
    mem_a   = {512{1'b1}};
    step();
    ready_a = 1'b1;
    wait_idle_a("snap_idle");

    // Ignored start in STREAM and in DONE
    ready_a = 1'b0;
    start_a_t(vec_a(11), 11, 1'b1, 3);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    ready_a = 1'b1;
    step();
    step();
    chk("ign_done_now", 64'(done_a), 64'd1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("ign_busy_after_done", 64'(busy_a), 64'd0);
    step();
    step();
    chk("ign_busy_stays_0", 64'(busy_a), 64'd0);
    chk("ign_valid_stays_0", 64'(valid_a), 64'd0);

    // Reset mid-stream with chunk 0 valid and unaccepted
    ready_a = 1'b0;
    start_a_t(vec_a(41), 41, 1'b0, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(valid_a), 64'd0);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_done", 64'(done_a), 64'd0);
    chk("mid_rst_index", 64'(idx_a), 64'd0);
    step();
    step();
    chk("mid_rst_no_done", 64'(done_a), 64'd0);
    ready_a = 1'b1;
    start_a_t(vec_a(21), 21, 1'b1, 2);
    wait_idle_a("mid_rst_restream_idle");

    // Exact multiple: 16 elements, 3 chunks, last chunk all zero
    ready_b = 1'b1;
    start_b_t(1, 3);
    wait_idle_b("b_idle");
    ready_b = 1'b0;
    start_b_t(201, 5);
    step();
    step();
    ready_b = 1'b1;
    wait_idle_b("b_bp_idle");

    step();
    step();
    chk("a_queue_empty", 64'(exp_a.size()), 64'd0);
    chk("a_done_queue_empty", 64'(done_cyc_a.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    chk("b_done_queue_empty", 64'(done_cyc_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
